// File: rtl/csr_pkg.sv
// Shared CSR definitions: window base, register offsets, access FSM encoding
// and the address-legality helper used by the access arbiter.
package csr_pkg;

   localparam logic [31:0] CSR_BASE = 32'hFFFF_F000;

   localparam logic [7:0] CSR_OFF_CTRL      = 8'h00;
   localparam logic [7:0] CSR_OFF_STATUS    = 8'h04;
   localparam logic [7:0] CSR_OFF_CYCLE_LO  = 8'h08;
   localparam logic [7:0] CSR_OFF_CYCLE_HI  = 8'h0C;
   localparam logic [7:0] CSR_OFF_INSTRET   = 8'h10;
   localparam logic [7:0] CSR_OFF_DBG_ID    = 8'hF0;
   localparam logic [7:0] CSR_OFF_DBG_SCR   = 8'hF4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } csr_state_e;

   // Out-of-window or non-word-aligned addresses are errors.
   function automatic logic csr_addr_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned win_bits);
      return ((addr >> win_bits) != (base >> win_bits)) || (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer
// advanced only when the caller signals that the grant was consumed.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   logic last_r;

   // Grant the lone requester, or on a tie the one not granted last.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_r ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Last-grant pointer; reset value 1 lets requester 0 win the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_r <= 1'b1;
      end else if (update) begin
         last_r <= gnt[1];
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/csr_access_arb.sv
// Arbitrates the core LSU and debug port onto the single perf/CSR read port,
// one transaction at a time with a fixed two-cycle accept-to-response latency.
module csr_access_arb #(
   parameter logic [31:0] CSR_BASE = csr_pkg::CSR_BASE,
   parameter int          WIN_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   output logic        rsp0_err,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   output logic        rsp1_err,
   input  logic        rsp1_ready,
   output logic [31:0] csr_addr,
   input  logic [31:0] csr_rdata,
   output logic        busy
);

   import csr_pkg::*;

   csr_state_e  state_r;
   csr_state_e  state_s;
   logic [31:0] addr_r;
   logic        id_r;
   logic [31:0] data_r;
   logic        err_r;
   logic [1:0]  req_s;
   logic [1:0]  gnt_s;
   logic [1:0]  ready_s;
   logic [1:0]  accept_s;
   logic        accept_any_s;
   logic        rsp_hs_s;
   logic        addr_err_s;

   assign req_s = {req1_valid, req0_valid};

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_s),
      .update (accept_any_s),
      .gnt    (gnt_s)
   );

   // Ready is gated by reset so nothing can be accepted while rst_n is low.
   always_comb begin
      ready_s = 2'b00;
      if ((state_r == IDLE) && rst_n) begin
         ready_s = gnt_s;
      end else begin
         ready_s = 2'b00;
      end
      accept_s     = req_s & ready_s;
      accept_any_s = |accept_s;
      rsp_hs_s     = id_r ? rsp1_ready : rsp0_ready;
      addr_err_s   = csr_addr_err(addr_r, CSR_BASE, WIN_BITS);
   end

   // Next-state logic for the IDLE -> ACCESS -> RESP cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_any_s) state_s = ACCESS;
            else              state_s = IDLE;
         end
         ACCESS: state_s = RESP;
         RESP: begin
            if (rsp_hs_s) state_s = IDLE;
            else          state_s = RESP;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, request latch and response capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         addr_r  <= CSR_BASE;
         id_r    <= 1'b0;
         data_r  <= 32'h0000_0000;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         if (accept_any_s) begin
            addr_r <= accept_s[1] ? req1_addr : req0_addr;
            id_r   <= accept_s[1];
         end
         if (state_r == ACCESS) begin
            err_r  <= addr_err_s;
            data_r <= addr_err_s ? 32'h0000_0000 : csr_rdata;
         end
      end
   end

   assign req0_ready = ready_s[0];
   assign req1_ready = ready_s[1];
   assign rsp0_valid = (state_r == RESP) && !id_r;
   assign rsp1_valid = (state_r == RESP) && id_r;
   assign rsp0_data  = data_r;
   assign rsp1_data  = data_r;
   assign rsp0_err   = err_r;
   assign rsp1_err   = err_r;
   assign csr_addr   = addr_r;
   assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_csr_access_arb.sv
// Directed bench for csr_access_arb with a small combinational CSR read model.
module tb_csr_access_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_addr, req1_addr;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_data, rsp1_data;
   logic        rsp0_err, rsp1_err;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] csr_addr;
   logic [31:0] csr_rdata;
   logic        busy;

   int total = 0;
   int bad   = 0;

   csr_access_arb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .rsp0_err   (rsp0_err),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .rsp1_err   (rsp1_err),
      .rsp1_ready (rsp1_ready),
      .csr_addr   (csr_addr),
      .csr_rdata  (csr_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Read model: 0xFFFF_F008 returns 0x123, anything else {addr[15:0], 16'hC5A0}.
   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (a == 32'hFFFF_F008) return 32'h0000_0123;
      else                    return {a[15:0], 16'hC5A0};
   endfunction

   always_comb csr_rdata = rd_model(csr_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int exp_id;
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req0_addr  = 32'hFFFF_F008;
      req1_valid = 1'b0;
      req1_addr  = 32'h0000_0000;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;

      // Reset: outputs quiet even with a request pending.
      tick();
      tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
      chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
      chk("rst_csr_addr", csr_addr, 32'hFFFF_F000);
      chk("rst_data", rsp0_data, 32'h0);
      chk("rst_err", {31'b0, rsp0_err}, 32'd0);
      req0_valid = 1'b0;
      rst_n      = 1'b1;
      #1;
      chk("idle_ready0_novalid", {31'b0, req0_ready}, 32'd0);

      // Single read by req0.
      req0_valid = 1'b1;
      req0_addr  = 32'hFFFF_F008;
      #1;
      chk("single_ready0", {31'b0, req0_ready}, 32'd1);
      chk("single_ready1", {31'b0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("single_acc_busy", {31'b0, busy}, 32'd1);
      chk("single_acc_addr", csr_addr, 32'hFFFF_F008);
      chk("single_acc_rspv", {31'b0, rsp0_valid}, 32'd0);
      tick();
      chk("single_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
      chk("single_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
      chk("single_data", rsp0_data, 32'h0000_0123);
      chk("single_err", {31'b0, rsp0_err}, 32'd0);
      tick();
      chk("single_done_busy", {31'b0, busy}, 32'd0);
      chk("single_done_rspv", {31'b0, rsp0_valid}, 32'd0);

      // Out-of-window read by req1.
      req1_valid = 1'b1;
      req1_addr  = 32'h0000_1000;
      #1;
      chk("oow_ready1", {31'b0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      chk("oow_acc_addr", csr_addr, 32'h0000_1000);
      tick();
      chk("oow_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("oow_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
      chk("oow_data", rsp1_data, 32'h0);
      chk("oow_err", {31'b0, rsp1_err}, 32'd1);
      tick();

      // Misaligned read by req0.
      req0_valid = 1'b1;
      req0_addr  = 32'hFFFF_F002;
      #1;
      chk("mis_ready0", {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      chk("mis_acc_addr", csr_addr, 32'hFFFF_F002);
      tick();
      chk("mis_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
      chk("mis_data", rsp0_data, 32'h0);
      chk("mis_err", {31'b0, rsp0_err}, 32'd1);
      tick();

      // Backpressure on rsp0 blocks req1.
      rsp0_ready = 1'b0;
      req0_valid = 1'b1;
      req0_addr  = 32'hFFFF_F004;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_addr  = 32'hFFFF_F0F0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
         chk("bp_data", rsp0_data, 32'hF004_C5A0);
         chk("bp_ready1", {31'b0, req1_ready}, 32'd0);
         chk("bp_busy", {31'b0, busy}, 32'd1);
         tick();
      end
      rsp0_ready = 1'b1;
      tick();
      chk("bp_rel_busy", {31'b0, busy}, 32'd0);
      chk("bp_rel_rspv", {31'b0, rsp0_valid}, 32'd0);
      chk("bp_rel_ready1", {31'b0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_data", rsp1_data, 32'hF0F0_C5A0);
      chk("bp_rsp1_err", {31'b0, rsp1_err}, 32'd0);
      tick();

      // Reset during ACCESS discards the transaction.
      req0_valid = 1'b1;
      req0_addr  = 32'hFFFF_F008;
      tick();
      req0_valid = 1'b0;
      chk("mid_acc_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_rsp0", {31'b0, rsp0_valid}, 32'd0);
         chk("mid_no_rsp1", {31'b0, rsp1_valid}, 32'd0);
         tick();
      end

      // Continuous tie: grants 0,1,0,1 with responses on their own ports.
      req0_valid = 1'b1;
      req0_addr  = 32'hFFFF_F00C;
      req1_valid = 1'b1;
      req1_addr  = 32'hFFFF_F010;
      for (int i = 0; i < 4; i++) begin
         exp_id = i % 2;
         #1;
         chk("tie_ready0", {31'b0, req0_ready}, (exp_id == 0) ? 32'd1 : 32'd0);
         chk("tie_ready1", {31'b0, req1_ready}, (exp_id == 1) ? 32'd1 : 32'd0);
         tick();
         tick();
         chk("tie_rsp0_valid", {31'b0, rsp0_valid}, (exp_id == 0) ? 32'd1 : 32'd0);
         chk("tie_rsp1_valid", {31'b0, rsp1_valid}, (exp_id == 1) ? 32'd1 : 32'd0);
         chk("tie_data", (exp_id == 0) ? rsp0_data : rsp1_data,
             (exp_id == 0) ? 32'hF00C_C5A0 : 32'hF010_C5A0);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csr_access_arb.md
CSR_ACCESS_ARB -- requirements
Module: csr_access_arb

Interface
REQ-001 The block SHALL have parameter CSR_BASE, default 32'hFFFF_F000, giving the base of the 256-byte CSR window.
REQ-002 The block SHALL have parameter WIN_BITS, default 8, giving the log2 of the window size in bytes.
REQ-003 The block SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 The block SHALL have ports reqN_valid  in  1, reqN_addr  in  32 and reqN_ready  out  1, for N=0 (core LSU) and N=1 (debug): the request handshake.
REQ-006 The block SHALL have ports rspN_valid  out  1, rspN_data  out  32, rspN_err  out  1 and rspN_ready  in  1, for N=0,1: the response handshake.
REQ-007 The block SHALL have port csr_addr  out  32  address driven to the perf/CSR read port.
REQ-008 The block SHALL have port csr_rdata  in  32  combinational read data returned for csr_addr.
REQ-009 The block SHALL have port busy  out  1, high whenever state != IDLE.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, ACCESS and RESP; one transaction is outstanding at a time.
REQ-011 reqN_ready SHALL be high only in IDLE, and only for the granted requester (combinational grant).
REQ-012 Grant SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins.
REQ-013 A request SHALL be accepted when reqN_valid && reqN_ready; the address and requester ID are latched and IDLE->ACCESS.
REQ-014 In ACCESS, csr_addr SHALL equal the latched address; csr_rdata is captured into the response register; ACCESS->RESP unconditionally.
REQ-015 Latency SHALL be fixed: acceptance in cycle N gives rsp_valid asserted in cycle N+2.
REQ-016 In RESP, rsp_valid SHALL be asserted only to the latched requester; data/err are held stable until rspN_ready; on handshake RESP->IDLE.
REQ-017 An out-of-window address ((addr >> WIN_BITS) != (CSR_BASE >> WIN_BITS)) SHALL yield err=1, data=32'h0.
REQ-018 A misaligned address (addr[1:0] != 0) SHALL yield err=1, data=32'h0.
REQ-019 An error transaction SHALL still take the ACCESS cycle, keeping latency fixed; only the captured data is forced to 0.
REQ-020 Outside ACCESS, csr_addr SHALL hold the last latched address (no glitch-driven reads).
REQ-021 A valid requester SHALL be able to deassert valid or change its address before acceptance with no effect; this is not a protocol error.
REQ-022 The last-grant pointer SHALL update only on acceptance.
REQ-023 Back-to-back requests SHALL be issued no faster than one per 3 cycles when responses are accepted immediately.
REQ-024 A requester stalling in RESP SHALL block the other requester; no timeout.

Reset
REQ-025 When rst_n is low at a clock edge: state=IDLE, last-grant=1 (req0 wins the first tie), latched address=CSR_BASE, response data=0, err=0.
REQ-026 During reset, all rsp_valid, reqN_ready and busy outputs SHALL be 0 from the first edge with rst_n low.
REQ-027 Reset asserted mid-transaction SHALL discard that transaction, with no response delivered after reset release.

Structure
REQ-028 CSR_BASE, the register offsets (0x00, 0x04, 0x08, 0x0C, 0x10, 0xF0, 0xF4) and the state encoding SHALL live in a shared package csr_pkg.
REQ-029 The 2-way round-robin grant SHALL be a sub-module rr_arb2 (inputs: req[1:0], update, clk, rst_n; output: gnt[1:0], one-hot or zero).
REQ-030 csr_access_arb SHALL be instantiated between the MEM stage / debug port and the perf/CSR read port, with its csr_addr/csr_rdata wired directly to it.

Verification
REQ-031 Single read: req0 reads 0xFFFF_F008 with csr_rdata model returning 0x0000_0123 -> rsp0_valid 2 cycles after accept, data 0x123, err 0.
REQ-032 Tie: both requesters valid continuously after reset -> grants in order 0,1,0,1; each response goes only to its own rsp port.
REQ-033 Errors: req1 reads 0x0000_1000 -> err 1, data 0; req0 reads 0xFFFF_F002 -> err 1, data 0; csr_addr is still driven in ACCESS and latency stays 2.
REQ-034 Backpressure: rsp0_ready held low for 5 cycles -> rsp0_valid and data stable throughout, req1 not accepted, busy=1; release -> IDLE next cycle.
REQ-035 Reset in ACCESS: rst_n low for 1 cycle -> no rsp_valid afterward, and the next tie grants req0.
